dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the memory end of the pipeline's load/store port. Accepts one word
//   request at a time over a valid/ready handshake, waits a programmable latency, returns a
//   response (read data or write ack) over a second valid/ready handshake.
// - Replaces the zero-latency DMemory array so the pipeline can be exercised against a stalling memory.
// PARAMETERS
// - DEPTH    1024  number of 32-bit words; legal word index 0..DEPTH-1
// - LATENCY  2     cycles from request acceptance to rsp_valid; legal range 1..15
// PORTS
// - clock       in   1   sole clock; all state changes on posedge
// - reset_n     in   1   synchronous, active-low reset
// - req_valid   in   1   request present
// - req_ready   out  1   responder can accept a request this cycle
// - req_we      in   1   1 = store, 0 = load
// - req_addr    in   32  byte address (word index = req_addr >> 2)
// - req_wdata   in   32  store data
// - req_be      in   4   byte enables, bit i -> wdata[8i+7:8i] (present only with DMEM_BYTE_WE_EN)
// - rsp_valid   out  1   response present
// - rsp_ready   in   1   requester takes response
// - rsp_rdata   out  32  load data; 0 for stores and errors
// - rsp_err     out  1   request was misaligned or out of range
// BEHAVIOUR
// - Reset (reset_n low at posedge): state IDLE, count 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
//   req_ready is 0 while reset_n is low. Memory contents are NOT reset.
// - Reset mid-operation aborts the transaction: pending store not committed, no response.
// - FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready = 1. On req_valid & req_ready, latch we/addr/wdata(/be), count <= LATENCY-1, go WAIT.
//   WAIT: req_ready = 0. count decrements each cycle; when count == 0, perform the access, go RESP.
//   RESP: rsp_valid = 1, rsp_rdata/rsp_err stable until rsp_valid & rsp_ready; then rsp_valid <= 0, go IDLE.
// - Latency: request accepted at edge N -> rsp_valid high after edge N+LATENCY.
// - A request is never accepted on the same edge as a response handshake. Minimum spacing between
//   acceptances is LATENCY+2 cycles.
// - Error: req_addr[1:0] != 0 or (req_addr >> 2) >= DEPTH -> rsp_err = 1, rsp_rdata = 0,
//   memory untouched. Error responses follow the same latency and handshake.
// - Store is committed to memory on the WAIT -> RESP edge. Response rsp_rdata = 0, rsp_err = 0.
// - Load: rsp_rdata = mem[index] sampled on the WAIT -> RESP edge.
//   A load after a store to the same word returns the stored value.
// - rsp_ready held low: RESP holds indefinitely and outputs stay constant; req_ready stays 0.
// - req_valid asserted outside IDLE is ignored and not queued. The requester must hold the request
//   until it is accepted.
// - Address arithmetic is unsigned 32-bit; upper address bits beyond DEPTH range count as out of range.
// CONFIGURATION
// - DMEM_BYTE_WE_EN defined: the req_be port exists. A store writes only the bytes whose be bit is 1.
//   be == 4'b0000 is a legal no-op store that still acknowledges. Loads ignore be.
// - DMEM_BYTE_WE_EN undefined: no req_be port; every store writes all 32 bits.
// TESTING
// - Reset, then store 0xDEADBEEF @0x10, LATENCY=2: accept at edge N, rsp_valid after N+2,
//   rsp_err=0, rsp_rdata=0; a following load @0x10 returns 0xDEADBEEF.
// - Load @0x13 (misaligned), then load @0x1000 with DEPTH=1024: both give rsp_err=1 and
//   rsp_rdata=0; memory is unchanged.
// - Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid/rsp_rdata stay constant and req_ready=0 throughout.
//   Raise rsp_ready: one handshake, then req_ready=1 the next cycle.
// - Assert reset_n=0 during WAIT of a store of 0x12345678 @0x20: no response appears, and a
//   later load @0x20 returns the old value.
// - With DMEM_BYTE_WE_EN: word @0x0 = 0xAABBCCDD, store 0x11223344 with be=4'b0101 ->
//   load returns 0xAA22CC44. be=0 gives an ack with the word unchanged.
// - Back-to-back: hold req_valid=1 continuously with rsp_ready=1 -> acceptances exactly LATENCY+2 cycles apart.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store port between the pipeline (master) and the data memory (slave).
// The req_be lane mask exists only when DMEM_BYTE_WE_EN is defined.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_WE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

`ifdef DMEM_BYTE_WE_EN
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory with programmable response latency.
// Define DMEM_BYTE_WE_EN to enable per-byte store masks via req_be.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic   clock,
  input  logic   reset_n,
  dmem_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("dmem_responder: LATENCY must be 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, access, rsp_fire, addr_err;
  logic [3:0]  be_in;

  logic [31:0] mem [DEPTH];

  // Full 32-bit compare so high address bits can never alias into range.
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> 2) >= 32'(DEPTH));

`ifdef DMEM_BYTE_WE_EN
  assign be_in = bus.req_be;
`else
  assign be_in = 4'hf;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    access        = 1'b0;
    rsp_fire      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = reset_n;
        if (bus.req_valid && reset_n) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = reset_n;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt         <= 4'(LATENCY - 1);
        req_q.we    <= bus.req_we;
        req_q.err   <= addr_err;
        req_q.idx   <= bus.req_addr[AW+1:2];
        req_q.wdata <= bus.req_wdata;
        req_q.be    <= be_in;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q   <= req_q.err;
        rdata_q <= (!req_q.we && !req_q.err) ? mem[req_q.idx] : 32'd0;
      end else if (rsp_fire) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Contents survive reset; access is already gated by reset_n.
  always_ff @(posedge clock) begin
    if (access && req_q.we && !req_q.err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.be[b]) mem[req_q.idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: latency, errors, backpressure, reset abort, throughput.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  rsp_t exp_q[$];
  logic [31:0] model [DEPTH];

  dmem_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Response monitor: a handshake completes on the edge after this sample.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output rsp_t e);
    logic        err;
    logic [9:0]  idx;
    logic [3:0]  eff_be;
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    idx = addr[11:2];
`ifdef DMEM_BYTE_WE_EN
    eff_be = be;
`else
    eff_be = be | 4'hf;
`endif
    e.err   = err;
    e.rdata = (!we && !err) ? model[idx] : 32'd0;
    if (we && !err)
      for (int b = 0; b < 4; b++)
        if (eff_be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
  endtask

  // Entered and left just after a posedge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit commit, output int acc);
    bit   ok;
    rsp_t e;
    ok = 1'b0;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
`ifdef DMEM_BYTE_WE_EN
    bus.req_be    = be;
`endif
    bus.req_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (bus.req_ready) ok = 1'b1;
    end
    chk("accept_seen", {31'd0, ok}, 32'd1);
    if (commit) begin
      model_apply(we, addr, wdata, be, e);
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, input int hold);
    bit          seen;
    logic [31:0] d0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rsp_seen", {31'd0, seen}, 32'd1);
    chk("latency", cyc - acc, LAT);
    if (hold > 0) begin
      d0 = bus.rsp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("hold_rdata", bus.rsp_rdata, d0);
        chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      @(posedge clock); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
    end
    @(negedge clock);
    chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold);
    int acc;
    bus.rsp_ready = (hold == 0);
    issue(we, addr, wdata, be, 1'b1, acc);
    wait_rsp(acc, hold);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int accs [3];
    int n;
    rsp_t e;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef DMEM_BYTE_WE_EN
    bus.req_be    = 4'hf;
`endif
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clock); #1;

    // Basic store/load and error cases
    txn(1'b1, 32'h10,  32'hDEADBEEF, 4'hf, 0);
    txn(1'b0, 32'h10,  32'h0,        4'hf, 0);
    txn(1'b1, 32'h20,  32'hCAFEF00D, 4'hf, 0);
    txn(1'b0, 32'h13,  32'h0,        4'hf, 0);
    txn(1'b0, 32'h1000, 32'h0,       4'hf, 0);
    txn(1'b1, 32'h11,  32'hFFFFFFFF, 4'hf, 0);
    txn(1'b1, 32'h8000_0010, 32'h55555555, 4'hf, 0);
    txn(1'b0, 32'h10,  32'h0,        4'hf, 0);
    txn(1'b1, 32'hFFC, 32'h0BADF00D, 4'hf, 0);
    txn(1'b0, 32'hFFC, 32'h0,        4'hf, 0);

    // Backpressure on the response side
    txn(1'b0, 32'h10, 32'h0, 4'hf, 5);

    // Reset during WAIT aborts the store
    bus.rsp_ready = 1'b1;
    issue(1'b1, 32'h20, 32'h12345678, 4'hf, 1'b0, acc);
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("abort_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clock); #1;
    txn(1'b0, 32'h20, 32'h0, 4'hf, 0);

`ifdef DMEM_BYTE_WE_EN
    txn(1'b1, 32'h0, 32'hAABBCCDD, 4'hf,    0);
    txn(1'b1, 32'h0, 32'h11223344, 4'b0101, 0);
    txn(1'b0, 32'h0, 32'h0,        4'h0,    0);
    txn(1'b1, 32'h0, 32'h55667788, 4'b0000, 0);
    txn(1'b0, 32'h0, 32'h0,        4'hf,    0);
`endif

    // Back-to-back: request held continuously
    bus.rsp_ready = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h10;
    bus.req_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        accs[n] = cyc + 1;
        model_apply(1'b0, 32'h10, 32'h0, 4'hf, e);
        exp_q.push_back(e);
        n++;
      end
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    chk("b2b_count", n, 3);
    chk("b2b_gap0", accs[1] - accs[0], LAT + 2);
    chk("b2b_gap1", accs[2] - accs[1], LAT + 2);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
